// File: rtl/fpu_norm_round.sv
// fpu_norm_round: normalize, round-to-nearest-even and pack a raw FP sum into IEEE-754 single.
// Define FPU_NORM_FAST_SHIFT_EN for a single-cycle leading-zero normalizer.
module fpu_norm_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);
  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;
  state_t state;
  logic sign, inx, stay, rnd_up, ovf, den;
  logic [9:0] exp, n_exp, r_exp;
  logic [27:0] mant, n_mant, r_mant, sum;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
`ifdef FPU_NORM_FAST_SHIFT_EN
  logic [9:0] lz, sh;
  always_comb begin
    lz = 10'd27;
    for (int i = 0; i <= 26; i++) if (mant[i]) lz = 10'(26 - i);
  end
  assign sh = lz < exp - 10'd1 ? lz : exp - 10'd1;
`endif
  always_comb begin
    n_mant = mant;
    n_exp = exp;
    stay = 1'b0;
    if (mant[27]) begin
      n_mant = {1'b0, mant[27:2], mant[1] | mant[0]};
      n_exp = exp + 10'd1;
    end else if (!mant[26] && exp > 10'd1) begin
`ifdef FPU_NORM_FAST_SHIFT_EN
      n_mant = mant << sh;
      n_exp = exp - sh;
`else
      n_mant = mant << 1;
      n_exp = exp - 10'd1;
      stay = !n_mant[26] && n_exp > 10'd1;
`endif
    end
  end
  // Ties go to the even neighbour; a rounding carry renormalizes in the same cycle.
  assign rnd_up = mant[2] && (mant[1] || mant[0] || mant[3]);
  assign sum = mant + (rnd_up ? 28'd8 : 28'd0);
  assign r_mant = sum[27] ? sum >> 1 : sum;
  assign r_exp = sum[27] ? exp + 10'd1 : exp;
  assign ovf = exp >= 10'd255;
  assign den = !mant[26];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sign <= 1'b0;
      inx <= 1'b0;
      exp <= '0;
      mant <= '0;
      data_out <= '0;
      status_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= in_sign;
          exp <= in_exp == 9'd0 ? 10'd1 : {1'b0, in_exp};
          mant <= in_mant;
          inx <= 1'b0;
          state <= NORM;
        end
        NORM: if (mant == 28'd0) begin
          data_out <= '0;
          status_out <= 4'b1000;
          state <= DONE;
        end else begin
          mant <= n_mant;
          exp <= n_exp;
          state <= stay ? NORM : ROUND;
        end
        ROUND: begin
          mant <= r_mant;
          exp <= r_exp;
          inx <= |mant[2:0];
          state <= PACK;
        end
        PACK: begin
          data_out <= ovf ? {sign, 31'h7F800000} : {sign, den ? 8'd0 : exp[7:0], mant[25:3]};
          status_out <= ovf ? 4'b0101 : {~inx, 1'b0, den & inx, inx};
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round: directed and randomized checks of fpu_norm_round against an arithmetic model.
module tb_fpu_norm_round;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b0;
  logic [8:0] in_exp = '0;
  logic [27:0] in_mant = '0;
  logic in_ready, out_valid;
  logic [31:0] data_out;
  logic [3:0] status_out;
  int checks = 0, failures = 0;
`ifdef FPU_NORM_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  always #5 clk = ~clk;
  fpu_norm_round dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .status_out(status_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask
  // Value-level model: normalize by MSB position, round the 3 dropped bits, then encode.
  task automatic model(input logic s, input int e_in, input longint m_in,
                       output logic [31:0] d, output logic [3:0] st, output int lat);
    longint m, keep, rem;
    int e, p, k;
    bit inx, den;
    m = m_in;
    e = e_in == 0 ? 1 : e_in;
    p = 0;
    k = 0;
    if (m == 0) begin
      d = '0;
      st = 4'b1000;
      lat = 1;
      return;
    end
    if (m >= (64'd1 << 27)) begin
      m = (m >> 1) | (m & 1);
      e++;
    end else begin
      for (int i = 0; i < 27; i++) if (((m >> i) & 1) == 1) p = i;
      k = 26 - p;
      if (k > e - 1) k = e - 1;
      m = m << k;
      e -= k;
    end
    lat = FAST ? 3 : 2 + (k > 1 ? k : 1);
    keep = m >> 3;
    rem = m & 7;
    inx = rem != 0;
    if (rem > 4 || (rem == 4 && (keep & 1) == 1)) keep++;
    if (keep >= (64'd1 << 24)) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) begin
      d = {s, 31'h7F800000};
      st = 4'b0101;
    end else begin
      den = keep < (64'd1 << 23);
      d = {s, den ? 8'd0 : 8'(e), 23'(keep)};
      st = {!inx, 1'b0, den && inx, inx};
    end
  endtask
  task automatic send(input logic s, input logic [8:0] e, input logic [27:0] m,
                      input logic [31:0] d, input logic [3:0] st, input int want_lat,
                      input int hold, input bit junk);
    int lat;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign = s;
    in_exp = e;
    in_mant = m;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 64) begin
      in_valid = junk;
      in_sign = 1'($urandom);
      in_exp = 9'($urandom);
      in_mant = 28'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'(want_lat));
    check("data", data_out, d);
    check("status", 32'(status_out), 32'(st));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_data", data_out, d);
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after", 32'(in_ready), 32'd1);
    check("valid_after", 32'(out_valid), 32'd0);
  endtask
  initial begin
    logic [31:0] d;
    logic [3:0] st;
    int lat;
    logic [8:0] e;
    logic [27:0] m;
    logic s;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_status", 32'(status_out), 32'd0);
    rst_n = 1'b1;
    send(1'b0, 9'd127, 28'h4000000, 32'h3F800000, 4'b1000, 3, 0, 1'b0);
    send(1'b0, 9'd127, 28'h8000000, 32'h40000000, 4'b1000, 3, 0, 1'b1);
    send(1'b0, 9'd254, 28'h8000000, 32'h7F800000, 4'b0101, 3, 2, 1'b0);
    send(1'b0, 9'd127, 28'h4000004, 32'h3F800000, 4'b0001, 3, 0, 1'b1);
    send(1'b0, 9'd127, 28'h400000C, 32'h3F800002, 4'b0001, 3, 0, 1'b0);
    send(1'b0, 9'd127, 28'h1000000, 32'h3E800000, 4'b1000, FAST ? 3 : 4, 0, 1'b1);
    send(1'b0, 9'd127, 28'h0000000, 32'h00000000, 4'b1000, 1, 0, 1'b1);
    send(1'b0, 9'd1, 28'h2000000, 32'h00400000, 4'b1000, 3, 10, 1'b1);
    send(1'b1, 9'd0, 28'h1000000, 32'h80200000, 4'b1000, 3, 0, 1'b0);
    in_valid = 1'b1;
    in_exp = 9'd127;
    in_mant = 28'h0000001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", data_out, 32'd0);
    check("midrst_status", 32'(status_out), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_quiet", 32'(out_valid), 32'd0);
    end
    for (int n = 0; n < 150; n++) begin
      s = 1'($urandom);
      e = $urandom_range(0, 3) == 0 ? 9'($urandom_range(0, 3)) :
          $urandom_range(0, 2) == 0 ? 9'($urandom_range(250, 256)) : 9'($urandom_range(0, 510));
      m = 28'($urandom) >> $urandom_range(0, 27);
      if ($urandom_range(0, 15) == 0) m = '0;
      model(s, int'(e), longint'(m), d, st, lat);
      send(s, e, m, d, st, lat, $urandom_range(0, 3), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
